writeback_unit: RTL and testbench

//   Write-back stage of the pipelined CPU and the sole write-side driver of the register file.
//   - Accepts one MEM/WB bundle per cycle.
//   - Selects the result source.
//   - Issues one register write, or two writes on consecutive cycles for dual-destination

---
 rtl/writeback_unit.sv | 119 +++++++++++
 tb/tb_writeback_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Write-back stage: selects the result source, drives the register-file write
// port (one write, or two on consecutive cycles for SWAP) and counts retired writes.
module writeback_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_wb_en,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [1:0]        i_src_sel,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [DATA_W-1:0] i_in_port,
    input  logic              i_dual,
    input  logic [ADDR_W-1:0] i_wb_addr2,
    input  logic [DATA_W-1:0] i_data2,
    output logic              o_rf_write,
    output logic [ADDR_W-1:0] o_rf_write_addr,
    output logic [DATA_W-1:0] o_rf_write_data,
    output logic [CNT_W-1:0]  o_write_count
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t            state, state_next;
    logic              accept;
    logic              first_qual;
    logic [DATA_W-1:0] first_data;
    logic              wr_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_next;
    logic [ADDR_W-1:0] addr2_q, addr2_next;
    logic [DATA_W-1:0] data2_q, data2_next;

    // Ready is a pure function of state, so upstream never sees a combinational path.
    assign o_ready    = (state == IDLE);
    assign accept     = i_valid && o_ready;
    assign first_qual = i_wb_en && (i_src_sel != 2'b11);

    // Result-source mux for the first write; "none" yields zero but is never written.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        first_data = '0;
        case (i_src_sel)
            2'b00:   first_data = i_alu_result;
            2'b01:   first_data = i_mem_data;
            2'b10:   first_data = i_in_port;
            default: first_data = '0;
        endcase
    end

    // Next-state and next-write decode; address/data hold unless a write is issued.
    always_comb begin
        state_next = state;
        wr_next    = 1'b0;
        addr_next  = o_rf_write_addr;
        data_next  = o_rf_write_data;
        addr2_next = addr2_q;
        data2_next = data2_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (first_qual) begin
                        wr_next   = 1'b1;
                        addr_next = i_wb_addr;
                        data_next = first_data;
                    end
                    if (i_dual) begin
                        addr2_next = i_wb_addr2;
                        data2_next = i_data2;
                        state_next = SECOND;
                    end
                end
            end
            SECOND: begin
                // Second write is unconditional: it belongs to an already-accepted SWAP.
                wr_next    = 1'b1;
                addr_next  = addr2_q;
                data_next  = data2_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, write port, latched second operand and retired-write counter.
    always_ff @(posedge i_clk or negedge i_reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (!i_reset) begin
            state           <= IDLE;
            o_rf_write      <= 1'b0;
            o_rf_write_addr <= '0;
            o_rf_write_data <= '0;
            addr2_q         <= '0;
            data2_q         <= '0;
            o_write_count   <= '0;
        end else begin
            state           <= state_next;
            o_rf_write      <= wr_next;
            o_rf_write_addr <= addr_next;
            o_rf_write_data <= data_next;
            addr2_q         <= addr2_next;
            data2_q         <= data2_next;
            if (wr_next) begin
                o_write_count <= o_write_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a vector table for single-cycle bundles plus
// hand-written sequences for SWAP, reset during the second write and counter wrap.
module tb_writeback_unit;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 4;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_valid;
    logic              o_ready;
    logic              i_wb_en;
    logic [ADDR_W-1:0] i_wb_addr;
    logic [1:0]        i_src_sel;
    logic [DATA_W-1:0] i_alu_result;
    logic [DATA_W-1:0] i_mem_data;
    logic [DATA_W-1:0] i_in_port;
    logic              i_dual;
    logic [ADDR_W-1:0] i_wb_addr2;
    logic [DATA_W-1:0] i_data2;
    logic              o_rf_write;
    logic [ADDR_W-1:0] o_rf_write_addr;
    logic [DATA_W-1:0] o_rf_write_data;
    logic [CNT_W-1:0]  o_write_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_wb_en         (i_wb_en),
        .i_wb_addr       (i_wb_addr),
        .i_src_sel       (i_src_sel),
        .i_alu_result    (i_alu_result),
        .i_mem_data      (i_mem_data),
        .i_in_port       (i_in_port),
        .i_dual          (i_dual),
        .i_wb_addr2      (i_wb_addr2),
        .i_data2         (i_data2),
        .o_rf_write      (o_rf_write),
        .o_rf_write_addr (o_rf_write_addr),
        .o_rf_write_data (o_rf_write_data),
        .o_write_count   (o_write_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic              valid;
        logic              wb_en;
        logic [1:0]        sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem;
        logic [DATA_W-1:0] inp;
        logic              exp_write;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid = 1'b0; i_wb_en = 1'b0; i_wb_addr = '0; i_src_sel = 2'b00;
        i_alu_result = '0; i_mem_data = '0; i_in_port = '0;
        i_dual = 1'b0; i_wb_addr2 = '0; i_data2 = '0;
    endtask

    task automatic alu_bundle(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        i_valid = 1'b1; i_wb_en = 1'b1; i_src_sel = 2'b00; i_wb_addr = a;
        i_alu_result = d; i_dual = 1'b0;
    endtask

    task automatic check_port(input string tag, input logic w, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, input logic rdy);
        check({tag, ".write"}, 32'(o_rf_write), 32'(w));
        check({tag, ".addr"},  32'(o_rf_write_addr), 32'(a));
        check({tag, ".data"},  32'(o_rf_write_data), 32'(d));
        check({tag, ".ready"}, 32'(o_ready), 32'(rdy));
        if (w) exp_count = (exp_count + 1) % (1 << CNT_W);
        check({tag, ".count"}, 32'(o_write_count), 32'(exp_count));
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        step();
        i_reset = 1'b1;
        exp_count = 0;
    endtask

    initial begin
        //        valid wb_en sel    addr  alu      mem      inp      write addr  data
        vecs[0] = '{1'b1, 1'b1, 2'b00, 3'd3, 16'h0060, 16'h0000, 16'h0000, 1'b1, 3'd3, 16'h0060};
        vecs[1] = '{1'b1, 1'b1, 2'b01, 3'd5, 16'h0001, 16'hBEEF, 16'h0002, 1'b1, 3'd5, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b1, 2'b10, 3'd6, 16'h0003, 16'h0004, 16'h1234, 1'b1, 3'd6, 16'h1234};
        vecs[3] = '{1'b1, 1'b1, 2'b11, 3'd7, 16'h5555, 16'h6666, 16'h7777, 1'b0, 3'd6, 16'h1234};
        vecs[4] = '{1'b1, 1'b0, 2'b00, 3'd2, 16'h1111, 16'h0000, 16'h0000, 1'b0, 3'd6, 16'h1234};
        vecs[5] = '{1'b0, 1'b1, 2'b00, 3'd1, 16'h2222, 16'h0000, 16'h0000, 1'b0, 3'd6, 16'h1234};
        vecs[6] = '{1'b1, 1'b1, 2'b00, 3'd0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 3'd0, 16'hFFFF};
        vecs[7] = '{1'b1, 1'b1, 2'b00, 3'd7, 16'h7777, 16'h0000, 16'h0000, 1'b1, 3'd7, 16'h7777};

        idle_inputs();
        i_reset = 1'b0;
        #1;
        check("reset_async.write", 32'(o_rf_write), 32'd0);
        check("reset_async.ready", 32'(o_ready), 32'd1);
        step();
        i_reset = 1'b1;
        step();
        check_port("post_reset", 1'b0, '0, '0, 1'b1);

        // Back-to-back single-write bundles, one per cycle.
        for (int i = 0; i < 8; i++) begin
            i_valid = vecs[i].valid; i_wb_en = vecs[i].wb_en; i_src_sel = vecs[i].sel;
            i_wb_addr = vecs[i].addr; i_alu_result = vecs[i].alu;
            i_mem_data = vecs[i].mem; i_in_port = vecs[i].inp; i_dual = 1'b0;
            step();
            check_port($sformatf("vec%0d", i), vecs[i].exp_write, vecs[i].exp_addr,
                       vecs[i].exp_data, 1'b1);
        end

        // SWAP followed by a held bundle that must be taken once ready returns.
        alu_bundle(3'd1, 16'h00AA);
        i_dual = 1'b1; i_wb_addr2 = 3'd2; i_data2 = 16'h0055;
        step();
        check_port("swap_first", 1'b1, 3'd1, 16'h00AA, 1'b0);
        alu_bundle(3'd4, 16'h0444);
        i_wb_addr2 = 3'd5; i_data2 = 16'h0999;
        step();
        check_port("swap_second", 1'b1, 3'd2, 16'h0055, 1'b1);
        step();
        check_port("held_bundle", 1'b1, 3'd4, 16'h0444, 1'b1);
        idle_inputs();
        step();
        check_port("idle_hold", 1'b0, 3'd4, 16'h0444, 1'b1);

        // SWAP with unqualified first write and same address for both halves.
        i_valid = 1'b1; i_wb_en = 1'b1; i_src_sel = 2'b11; i_wb_addr = 3'd3;
        i_dual = 1'b1; i_wb_addr2 = 3'd3; i_data2 = 16'h0BAD;
        step();
        check_port("swap_nofirst", 1'b0, 3'd4, 16'h0444, 1'b0);
        idle_inputs();
        step();
        check_port("swap_nofirst2", 1'b1, 3'd3, 16'h0BAD, 1'b1);

        // Same-address SWAP: both writes issue, second value last.
        alu_bundle(3'd6, 16'h0101);
        i_dual = 1'b1; i_wb_addr2 = 3'd6; i_data2 = 16'h0202;
        step();
        check_port("same_addr1", 1'b1, 3'd6, 16'h0101, 1'b0);
        idle_inputs();
        step();
        check_port("same_addr2", 1'b1, 3'd6, 16'h0202, 1'b1);

        // Reset while the second write is pending drops it.
        alu_bundle(3'd1, 16'h00AA);
        i_dual = 1'b1; i_wb_addr2 = 3'd2; i_data2 = 16'h0055;
        step();
        check("rst_sec.pre_ready", 32'(o_ready), 32'd0);
        idle_inputs();
        #2 i_reset = 1'b0;
        #1;
        exp_count = 0;
        check_port("rst_second", 1'b0, '0, '0, 1'b1);
        step();
        i_reset = 1'b1;
        step();
        check_port("rst_release", 1'b0, '0, '0, 1'b1);
        step();
        check_port("rst_release2", 1'b0, '0, '0, 1'b1);

        // Counter wraps modulo 2^CNT_W: 17 writes leave it at 1.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            alu_bundle(3'(i), 16'(i + 1));
            step();
        end
        idle_inputs();
        check("wrap.count", 32'(o_write_count), 32'd1);
        check("wrap.last_data", 32'(o_rf_write_data), 32'h0011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
